shift_reg_burst: RTL and testbench

Parametrised universal shift register with a burst sequencer. It is the next generation of the team's 4-bit LOAD/PUSH/CYCLE shift register: the width is a parameter, and a single START request executes CNT consecutive shift or rotate steps without further stimulus. A BUSY/DONE handshake reports progress. It sits beside the limit-switch FSM and is driven by the same `tester`-style bench through `CLK`/`ENB`.

---
 rtl/shift_reg_burst_pkg.sv | 19 +
 rtl/shift_reg_burst_shift_step.sv | 40 ++++
 rtl/shift_reg_burst.sv | 145 ++++++++++++++
 tb/tb_shift_reg_burst.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/shift_reg_burst_pkg.sv
// Shared types for the burst shift register.
//   mode_e  : operation requested on MODO (HOLD/LOAD/PUSH/CYCLE)
//   state_e : sequencer state, 2-bit encoding
package shift_reg_burst_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_PUSH  = 2'b10,
    MODE_CYCLE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_burst_shift_step.sv
// One combinational shift/rotate step of the register.
// Ports:
//   q          : current register contents
//   s_in       : serial input used by PUSH
//   mode       : PUSH shifts s_in in, CYCLE feeds the outgoing bit back in
//   dir        : 0 = toward MSB, 1 = toward LSB
//   q_next     : register contents after the step
//   s_out_next : bit that leaves the register on this step
module shift_step
  import shift_reg_burst_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             s_in,
  input  mode_e            mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q_next,
  output logic             s_out_next
);

  logic fill;

  always_comb begin
    fill       = s_in;
    q_next     = q;
    s_out_next = 1'b0;
    if (mode == MODE_CYCLE) begin
      fill = dir ? q[0] : q[WIDTH-1];
    end
    if (dir) begin
      q_next     = {fill, q[WIDTH-1:1]};
      s_out_next = q[0];
    end else begin
      q_next     = {q[WIDTH-2:0], fill};
      s_out_next = q[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_reg_burst.sv
// Universal shift register with a burst sequencer: one START runs CNT
// shift/rotate steps, reporting progress on BUSY and a one-cycle DONE.
// Ports:
//   CLK, RST (sync, active-high), ENB (0 freezes everything)
//   START, MODO, DIR, S_IN, D, CNT : request and operands
//   Q, S_OUT, BUSY, DONE           : registered outputs
//
// state  | meaning
// IDLE   | waiting for START
// RUN    | one step per enabled edge until the counter reaches 0
// FINISH | DONE high for one enabled cycle
module shift_reg_burst
  import shift_reg_burst_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             START,
  input  logic [1:0]       MODO,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_q;
  logic             step_s_out;
  mode_e            req_mode;

  assign req_mode = mode_e'(MODO);

  // Steps always use the operands latched at START, so MODO/DIR may move freely mid-burst.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q          (q_q),
    .s_in       (S_IN),
    .mode       (mode_q),
    .dir        (dir_q),
    .q_next     (step_q),
    .s_out_next (step_s_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    s_out_d = s_out_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (ENB) begin
      case (state_q)
        ST_IDLE: begin
          done_d = 1'b0;
          if (START) begin
            case (req_mode)
              MODE_LOAD: begin
                q_d     = D;
                done_d  = 1'b1;
                state_d = ST_FINISH;
              end
              MODE_PUSH, MODE_CYCLE: begin
                if (CNT == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_FINISH;
                end else begin
                  mode_d  = req_mode;
                  dir_d   = DIR;
                  cnt_d   = CNT;
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          q_d     = step_q;
          s_out_d = step_s_out;
          cnt_d   = cnt_q - CW'(1);
          // Terminal count: this edge performs the last step.
          if (cnt_q == CW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
      s_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = s_out_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_shift_reg_burst.sv
module tb_shift_reg_burst;

  logic       CLK = 1'b0;
  logic       RST, ENB, START, DIR, S_IN;
  logic [1:0] MODO;
  logic [3:0] D, CNT;
  logic [3:0] Q;
  logic       S_OUT, BUSY, DONE;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  shift_reg_burst #(.WIDTH(4), .CW(4)) dut (
    .CLK(CLK), .RST(RST), .ENB(ENB), .START(START), .MODO(MODO),
    .DIR(DIR), .S_IN(S_IN), .D(D), .CNT(CNT),
    .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic expect_next(input string tag, input logic [3:0] q,
                             input logic sout, input logic busy, input logic done);
    exp_t e;
    e.tag = tag; e.q = q; e.sout = sout; e.busy = busy; e.done = done;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare the DUT against the oldest expectation.
  task automatic cyc();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"},    Q,             e.q);
      chk({e.tag, ".sout"}, {3'b0, S_OUT}, {3'b0, e.sout});
      chk({e.tag, ".busy"}, {3'b0, BUSY},  {3'b0, e.busy});
      chk({e.tag, ".done"}, {3'b0, DONE},  {3'b0, e.done});
    end
  endtask

  task automatic step(input string tag, input logic [3:0] q,
                      input logic sout, input logic busy, input logic done);
    expect_next(tag, q, sout, busy, done);
    cyc();
  endtask

  initial begin
    RST = 1'b1; ENB = 1'b1; START = 1'b0; MODO = 2'b00; DIR = 1'b0;
    S_IN = 1'b0; D = 4'h0; CNT = 4'h0;
    @(negedge CLK);
    step("reset", 4'b0000, 0, 0, 0);
    RST = 1'b0;

    // LOAD ignores CNT and DIR
    D = 4'b1101; MODO = 2'b01; CNT = 4'd7; DIR = 1'b1; START = 1'b1;
    step("load_k", 4'b1101, 0, 0, 1);
    START = 1'b0;
    step("load_idle", 4'b1101, 0, 0, 0);

    // PUSH left, S_IN=0, CNT=3
    MODO = 2'b10; DIR = 1'b0; S_IN = 1'b0; CNT = 4'd3; START = 1'b1;
    step("pushl_k", 4'b1101, 0, 1, 0);
    START = 1'b0;
    step("pushl_1", 4'b1010, 1, 1, 0);
    step("pushl_2", 4'b0100, 1, 1, 0);
    step("pushl_3", 4'b1000, 0, 0, 1);
    step("pushl_idle", 4'b1000, 0, 0, 0);

    // CYCLE right wrap-around with garbage on the ignored inputs mid-burst
    D = 4'b0110; MODO = 2'b01; START = 1'b1;
    step("load2_k", 4'b0110, 0, 0, 1);
    START = 1'b0;
    step("load2_idle", 4'b0110, 0, 0, 0);
    MODO = 2'b11; DIR = 1'b1; CNT = 4'd4; START = 1'b1;
    step("cycr_k", 4'b0110, 0, 1, 0);
    MODO = 2'b01; D = 4'b1111; CNT = 4'd0; DIR = 1'b0; START = 1'b1;
    step("cycr_1", 4'b0011, 0, 1, 0);
    step("cycr_2", 4'b1001, 1, 1, 0);
    step("cycr_3", 4'b1100, 1, 1, 0);
    step("cycr_4", 4'b0110, 0, 0, 1);
    step("finish_start_ignored", 4'b0110, 0, 0, 0);
    START = 1'b0;

    // CNT=0: DONE with Q unchanged
    MODO = 2'b10; CNT = 4'd0; START = 1'b1;
    step("cnt0_k", 4'b0110, 0, 0, 1);
    START = 1'b0;
    step("cnt0_idle", 4'b0110, 0, 0, 0);

    // HOLD request is ignored
    MODO = 2'b00; START = 1'b1;
    step("hold", 4'b0110, 0, 0, 0);
    START = 1'b0;

    // ENB stall during CYCLE left CNT=2, plus a stall while DONE is high
    D = 4'b1010; MODO = 2'b01; START = 1'b1;
    step("load3_k", 4'b1010, 0, 0, 1);
    START = 1'b0;
    step("load3_idle", 4'b1010, 0, 0, 0);
    MODO = 2'b11; DIR = 1'b0; CNT = 4'd2; START = 1'b1;
    step("cycl_k", 4'b1010, 0, 1, 0);
    START = 1'b0;
    step("cycl_1", 4'b0101, 1, 1, 0);
    ENB = 1'b0;
    for (int i = 0; i < 3; i++) step("stall", 4'b0101, 1, 1, 0);
    ENB = 1'b1;
    step("cycl_2", 4'b1010, 0, 0, 1);
    ENB = 1'b0;
    step("done_hold", 4'b1010, 0, 0, 1);
    ENB = 1'b1;
    step("cycl_idle", 4'b1010, 0, 0, 0);

    // PUSH right with live S_IN
    MODO = 2'b10; DIR = 1'b1; CNT = 4'd2; S_IN = 1'b1; START = 1'b1;
    step("pushr_k", 4'b1010, 0, 1, 0);
    START = 1'b0;
    step("pushr_1", 4'b1101, 0, 1, 0);
    S_IN = 1'b0;
    step("pushr_2", 4'b0110, 1, 0, 1);
    step("pushr_idle", 4'b0110, 1, 0, 0);

    // Reset mid-burst, second reset edge with ENB low
    MODO = 2'b11; DIR = 1'b0; CNT = 4'd5; START = 1'b1;
    step("rstb_k", 4'b0110, 1, 1, 0);
    START = 1'b0;
    step("rstb_1", 4'b1100, 0, 1, 0);
    RST = 1'b1;
    step("rst_mid1", 4'b0000, 0, 0, 0);
    ENB = 1'b0;
    step("rst_mid2", 4'b0000, 0, 0, 0);
    RST = 1'b0; ENB = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 4'b0000, 0, 0, 0);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_left: observed %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
